// File: rtl/fsm_4s1i1o_steer_driver.sv
// Drives the 4-state Mealy FSM's in_ bit along a shortest path to a requested
// target state, tracking the FSM state and the expected Mealy output per bit.
module fsm_4s1i1o_steer_driver #(
   parameter logic [1:0] INIT_STATE = 2'd0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_val,
   output logic       req_rdy,
   input  logic [1:0] req_target,
   output logic       in_val,
   input  logic       in_rdy,
   output logic       in_,
   output logic       out_exp,
   output logic [1:0] cur_state,
   output logic       done,
   output logic [1:0] steps
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_STEER = 2'd1, S_DONE = 2'd2} ctl_e;

   ctl_e       ctl_q, ctl_d;
   logic [1:0] cur_q, cur_d;
   logic [1:0] tgt_q, tgt_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] steps_q, steps_d;
   logic       bit_c;
   logic [1:0] nxt_c;

   // First bit of the shortest path; ties resolve to 0.
   function automatic logic first_bit(input logic [1:0] cur, input logic [1:0] tgt);
      case ({cur, tgt})
         4'b00_01, 4'b00_10, 4'b00_11: first_bit = 1'b1;
         4'b10_11:                     first_bit = 1'b1;
         4'b11_01:                     first_bit = 1'b1;
         default:                      first_bit = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] fsm_next(input logic [1:0] cur, input logic b);
      case (cur)
         2'd0:    fsm_next = b ? 2'd1 : 2'd0;
         2'd1:    fsm_next = b ? 2'd1 : 2'd2;
         2'd2:    fsm_next = b ? 2'd3 : 2'd0;
         default: fsm_next = b ? 2'd1 : 2'd2;
      endcase
   endfunction

   function automatic logic fsm_out(input logic [1:0] cur, input logic b);
      case (cur)
         2'd0:    fsm_out = b;
         2'd1:    fsm_out = ~b;
         2'd2:    fsm_out = b;
         default: fsm_out = 1'b0;
      endcase
   endfunction

   always_comb begin
      ctl_d   = ctl_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      steps_d = steps_q;
      req_rdy = 1'b0;
      in_val  = 1'b0;
      in_     = 1'b0;
      out_exp = 1'b0;
      done    = 1'b0;
      bit_c   = first_bit(cur_q, tgt_q);
      nxt_c   = fsm_next(cur_q, bit_c);
      case (ctl_q)
         S_IDLE: begin
            // Not ready while reset is held, even though the state is IDLE.
            req_rdy = reset_n;
            if (req_val && reset_n) begin
               tgt_d = req_target;
               cnt_d = 2'd0;
               if (req_target == cur_q) begin
                  ctl_d   = S_DONE;
                  steps_d = 2'd0;
               end else begin
                  ctl_d = S_STEER;
               end
            end
         end
         S_STEER: begin
            in_val  = 1'b1;
            in_     = bit_c;
            out_exp = fsm_out(cur_q, bit_c);
            if (in_rdy) begin
               cur_d = nxt_c;
               cnt_d = cnt_q + 2'd1;
               // steps is loaded on entry to DONE so it is valid alongside the pulse.
               if (nxt_c == tgt_q) begin
                  ctl_d   = S_DONE;
                  steps_d = cnt_q + 2'd1;
               end
            end
         end
         S_DONE: begin
            done  = 1'b1;
            ctl_d = S_IDLE;
         end
         default: ctl_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctl_q   <= S_IDLE;
         cur_q   <= INIT_STATE;
         tgt_q   <= 2'd0;
         cnt_q   <= 2'd0;
         steps_q <= 2'd0;
      end else begin
         ctl_q   <= ctl_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         steps_q <= steps_d;
      end
   end

   assign cur_state = cur_q;
   assign steps     = steps_q;

endmodule

// File: tb/tb_fsm_4s1i1o_steer_driver.sv
// Randomized and directed bench for the steer driver against a path-search model.
module tb_fsm_4s1i1o_steer_driver;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_val = 1'b0;
   logic       req_rdy;
   logic [1:0] req_target = 2'd0;
   logic       in_val;
   logic       in_rdy = 1'b0;
   logic       in_;
   logic       out_exp;
   logic [1:0] cur_state;
   logic       done;
   logic [1:0] steps;

   int n_chk = 0;
   int n_fail = 0;
   int mcur = 0;

   // FSM table as data: next state and Mealy output indexed [state][bit].
   int tnext [4][2] = '{'{0, 1}, '{2, 1}, '{0, 3}, '{2, 1}};
   int tout  [4][2] = '{'{0, 1}, '{1, 0}, '{0, 1}, '{0, 0}};

   fsm_4s1i1o_steer_driver #(.INIT_STATE(2'd0)) dut (
      .clk(clk), .reset_n(reset_n), .req_val(req_val), .req_rdy(req_rdy),
      .req_target(req_target), .in_val(in_val), .in_rdy(in_rdy), .in_(in_),
      .out_exp(out_exp), .cur_state(cur_state), .done(done), .steps(steps)
   );

   always #5 clk = ~clk;

   // Enumerate bit strings by length, then with 0-first ordering, and return
   // the first bit of the first string that lands on the target.
   function automatic int model_bit(input int cur, input int tgt);
      for (int len = 1; len <= 3; len++)
         for (int v = 0; v < (1 << len); v++) begin
            int s = cur;
            for (int k = len - 1; k >= 0; k--) s = tnext[s][(v >> k) & 1];
            if (s == tgt) return (v >> (len - 1)) & 1;
         end
      return 0;
   endfunction

   // One request; returns emitted bits (first bit in MSB of n bits), expected
   // outputs and bit count. stall_first holds in_rdy low that many cycles on bit 0.
   task automatic run_req(input int tgt, input int stall_first, input int stall_pct,
                          output int bits, output int outs, output int nb);
      int k, stalls, b, o, exp_lat, waitc;
      logic rdy;
      bits = 0; outs = 0; nb = 0; stalls = 0; waitc = 0;
      @(negedge clk);
      while (!req_rdy && waitc < 10) begin @(negedge clk); waitc++; end
      n_chk++;
      if (req_rdy !== 1'b1) begin
         n_fail++; $display("FAIL req_rdy_wait: got %b want 1", req_rdy);
      end
      req_val = 1'b1; req_target = 2'(tgt);
      @(posedge clk); #1;
      req_val = 1'b0; req_target = 2'($urandom_range(3, 0));
      k = 0;
      while (k < 30) begin
         @(negedge clk); k++;
         if (mcur == tgt) begin
            exp_lat = nb + 1 + stalls;
            n_chk++;
            if (done !== 1'b1 || in_val !== 1'b0 || req_rdy !== 1'b0 || out_exp !== 1'b0
                || k != exp_lat) begin
               n_fail++;
               $display("FAIL done_pulse tgt=%0d: done=%b in_val=%b rdy=%b out_exp=%b cyc=%0d want done=1 0 0 0 cyc=%0d",
                        tgt, done, in_val, req_rdy, out_exp, k, exp_lat);
            end
            break;
         end
         b = model_bit(mcur, tgt);
         o = tout[mcur][b];
         n_chk++;
         if (in_val !== 1'b1 || in_ !== b[0] || out_exp !== o[0] || cur_state !== 2'(mcur)
             || done !== 1'b0 || req_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL steer_beat tgt=%0d: in_val=%b in_=%b out_exp=%b cur=%0d done=%b want 1 %0d %0d %0d 0",
                     tgt, in_val, in_, out_exp, cur_state, done, b, o, mcur);
         end
         if (nb == 0 && stalls < stall_first) rdy = 1'b0;
         else rdy = ($urandom_range(99, 0) >= stall_pct);
         in_rdy = rdy;
         @(posedge clk); #1;
         in_rdy = 1'b0;
         if (rdy) begin
            bits = (bits << 1) | b; outs = (outs << 1) | o; nb++;
            mcur = tnext[mcur][b];
         end else stalls++;
      end
      @(negedge clk);
      n_chk++;
      if (steps !== 2'(nb) || done !== 1'b0 || req_rdy !== 1'b1 || cur_state !== 2'(mcur)) begin
         n_fail++;
         $display("FAIL post_done tgt=%0d: steps=%0d done=%b rdy=%b cur=%0d want %0d 0 1 %0d",
                  tgt, steps, done, req_rdy, cur_state, nb, mcur);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      #12;
      n_chk++;
      if (req_rdy !== 0 || in_val !== 0 || in_ !== 0 || out_exp !== 0 || done !== 0
          || steps !== 0 || cur_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy=%b in_val=%b in_=%b out=%b done=%b steps=%0d cur=%0d want all 0",
                  req_rdy, in_val, in_, out_exp, done, steps, cur_state);
      end
      @(negedge clk); reset_n = 1'b1; mcur = 0;
      @(negedge clk);
      n_chk++;
      if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_rdy: got %b want 1", req_rdy); end
   endtask

   task automatic check_seq(input string name, input int bits, input int outs, input int nb,
                            input int eb, input int eo, input int en);
      n_chk++;
      if (bits != eb || outs != eo || nb != en || cur_state !== 2'(mcur)) begin
         n_fail++;
         $display("FAIL %s: bits=%b outs=%b n=%0d want bits=%b outs=%b n=%0d", name, 3'(bits), 3'(outs), nb,
                  3'(eb), 3'(eo), en);
      end
   endtask

   task automatic test_paths;
      int b, o, n;
      run_req(3, 0, 0, b, o, n); check_seq("a_to_d", b, o, n, 3'b101, 3'b111, 3);
      run_req(0, 0, 0, b, o, n); check_seq("d_to_a", b, o, n, 2'b00, 2'b00, 2);
      run_req(2, 0, 0, b, o, n); check_seq("a_to_c", b, o, n, 2'b10, 2'b11, 2);
      run_req(1, 0, 0, b, o, n); check_seq("c_to_b_tie", b, o, n, 2'b01, 2'b01, 2);
      run_req(1, 0, 0, b, o, n); check_seq("b_same", b, o, n, 0, 0, 0);
      run_req(0, 0, 0, b, o, n); check_seq("b_to_a", b, o, n, 2'b00, 2'b10, 2);
   endtask

   task automatic test_stall;
      int b, o, n;
      run_req(2, 3, 0, b, o, n); check_seq("stall_a_to_c", b, o, n, 2'b10, 2'b11, 2);
      run_req(0, 0, 0, b, o, n); check_seq("c_to_a", b, o, n, 1'b0, 1'b0, 1);
   endtask

   task automatic test_reset_mid;
      int seen_done = 0;
      @(negedge clk);
      req_val = 1'b1; req_target = 2'd3;
      @(posedge clk); #1 req_val = 1'b0; in_rdy = 1'b1;
      @(posedge clk); #1 in_rdy = 1'b0;
      @(negedge clk);
      n_chk++;
      if (cur_state !== 2'd1 || in_val !== 1'b1) begin
         n_fail++; $display("FAIL mid_pre: cur=%0d in_val=%b want 1 1", cur_state, in_val);
      end
      reset_n = 1'b0; #1;
      n_chk++;
      if (cur_state !== 2'd0 || in_val !== 0 || done !== 0 || req_rdy !== 0) begin
         n_fail++; $display("FAIL mid_reset: cur=%0d in_val=%b done=%b rdy=%b want 0 0 0 0",
                            cur_state, in_val, done, req_rdy);
      end
      @(negedge clk); reset_n = 1'b1; mcur = 0;
      for (int i = 0; i < 4; i++) begin @(negedge clk); if (done) seen_done++; end
      n_chk++;
      if (seen_done != 0 || req_rdy !== 1'b1 || cur_state !== 2'd0) begin
         n_fail++; $display("FAIL mid_release: dones=%0d rdy=%b cur=%0d want 0 1 0", seen_done, req_rdy, cur_state);
      end
   endtask

   task automatic test_random;
      int b, o, n;
      for (int i = 0; i < 40; i++) run_req($urandom_range(3, 0), 0, 30, b, o, n);
   endtask

   initial begin
      test_reset;
      test_paths;
      test_stall;
      test_reset_mid;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fsm_4s1i1o_steer_driver.md
Name: fsm_4s1i1o_steer_driver

Overview:
- Stimulus-side driver for the 4-state, 1-input, 1-output Mealy FSM used across this design (states A=0, B=1, C=2, D=3).
- Accepts a target-state request over a val/rdy handshake and emits a serial in_ bit stream, one bit per accepted beat, that steers the FSM along a shortest path to the target.
- Tracks the FSM's state internally and reports the expected Mealy output for every emitted bit.
- Sits in front of the combinational FSM core: either as a bench driver or as the sequencing block that owns the FSM's input.

Parameters:
- INIT_STATE, 2'd0, tracked FSM state loaded on reset (A).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_val  input  1  target request valid
- req_rdy  output  1  driver can accept a request
- req_target  input  2  requested FSM state
- in_val  output  1  in_ bit is valid this cycle
- in_rdy  input  1  downstream consumes in_ this cycle
- in_  output  1  serial input bit for the FSM
- out_exp  output  1  expected Mealy output for (cur_state, in_); valid when in_val=1, otherwise 0
- cur_state  output  2  tracked FSM state
- done  output  1  one-cycle pulse when the tracked state equals the latched target
- steps  output  2  number of bits emitted for the last completed request; held until the next done

Behaviour:
- FSM table, given as state: in_=0 -> next/out ; in_=1 -> next/out:
  - A: 0->A/0 ; 1->B/1
  - B: 0->C/1 ; 1->B/0
  - C: 0->A/0 ; 1->D/1
  - D: 0->C/0 ; 1->B/0
- Next-bit rule:
  - in_ is the first bit of a shortest path from cur_state to the target.
  - On a tie, in_=0 is chosen.
  - Resulting paths, from->to: bits:
    - A->B:1, A->C:10, A->D:101
    - B->A:00, B->C:0, B->D:01
    - C->A:0, C->B:01, C->D:1
    - D->A:00, D->B:1, D->C:0, D->D:01 only when re-entry is forced (never; see below)
  - Maximum path length is 3.
- Control states: IDLE, STEER, DONE.
- Reset (asynchronous, reset_n=0):
  - control state IDLE, cur_state=INIT_STATE, target=0, steps=0, bit counter=0
  - req_rdy=1 only after release; during reset all outputs are 0 except cur_state
- IDLE:
  - req_rdy=1, in_val=0, done=0.
  - On req_val&&req_rdy: latch req_target and clear the bit counter.
  - If req_target==cur_state, go to DONE (zero bits emitted). Otherwise go to STEER.
- STEER:
  - req_rdy=0, in_val=1.
  - in_ and out_exp are combinational from (cur_state, target).
  - On in_val&&in_rdy: cur_state<=next, counter++.
  - If next==target, go to DONE.
  - With in_rdy=0: hold in_, out_exp and cur_state stable; no advance.
- DONE:
  - done=1 for exactly one cycle, req_rdy=0, in_val=0, steps<=counter.
  - Then go to IDLE.
- Latency:
  - Request accept to done = N+1 cycles for an N-bit path with in_rdy held high.
  - A request whose target equals the current state gives done 1 cycle after accept, with steps=0.
- req_val while req_rdy=0 is ignored; the requester holds it.
- A change on req_target after accept has no effect.
- reset_n asserted mid-STEER: immediate return to IDLE, cur_state=INIT_STATE, no done pulse.
- No back-to-back accept in the DONE cycle; the earliest next accept is the IDLE cycle after done.

Test Plan:
- Reset, then req_target=3 with in_rdy=1 -> in_ sequence 1,0,1 and out_exp 1,1,1 on consecutive cycles; cur_state 0->1->2->3; done on cycle 4 after accept; steps=3.
- From D, req_target=0 -> in_ 0,0, out_exp 0,0, cur_state 3->2->0, steps=2.
- From C, req_target=1 -> tie resolved to in_ 0,1, out_exp 0,1, cur_state 2->0->1.
- req_target equal to cur_state (B) -> no in_val, done 1 cycle after accept, steps=0, cur_state unchanged.
- From A, req_target=2 with in_rdy low for 3 cycles on the first bit -> in_=1 and out_exp=1 held stable, cur_state stays 0, then completes 1,0; steps=2.
- reset_n pulsed low during STEER of A->D after the first bit -> cur_state=0 immediately, in_val=0, no done, req_rdy=1 after release.
